tank_controller: RTL

TANK_CONTROLLER -- requirements
Module: tank_controller

---
 rtl/tank_controller.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/tank_controller.sv
// Grid-locked tank movement controller.
// Steps the tank one 32-pixel cell at a time on frame ticks.
module tank_controller #(
    parameter logic [9:0] START_X   = 10'd32,
    parameter logic [9:0] START_Y   = 10'd32,
    parameter logic [9:0] STEP      = 10'd2,
    parameter logic [7:0] KEY_UP    = 8'h1A,
    parameter logic [7:0] KEY_DOWN  = 8'h16,
    parameter logic [7:0] KEY_LEFT  = 8'h04,
    parameter logic [7:0] KEY_RIGHT = 8'h07
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] TankX,
    output logic [9:0] TankY,
    output logic [1:0] TankDir,
    output logic       Moving
);

    localparam logic [9:0] CELL  = 10'd32;
    localparam logic [9:0] X_MAX = 10'd608;
    localparam logic [9:0] Y_MAX = 10'd448;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        MOVE = 1'b1
    } state_t;

    // Frame strobe synchroniser and edge detector
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic val1_q;
    logic val2_q;
    logic armed_q;
    logic tick;

    // val1/val2 mark when sync2 carries a real sample after reset;
    // armed means the strobe has been seen low since reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            val1_q  <= 1'b0;
            val2_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            val1_q  <= 1'b1;
            val2_q  <= val1_q;
            armed_q <= armed_q | (val2_q & ~sync2_q);
        end
    end

    assign tick = armed_q & sync2_q & ~prev_q;

    // Movement state
    state_t     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [1:0] dir_q, dir_d;
    logic       moving_q, moving_d;

    // Keycode decode
    logic       key_valid;
    logic [1:0] key_dir;

    // Map the pressed key to a direction; anything else is no key
    always_comb begin
        key_valid = 1'b0;
        key_dir   = DIR_UP;
        unique case (1'b1)
            (keycode == KEY_UP): begin
                key_valid = 1'b1;
                key_dir   = DIR_UP;
            end
            (keycode == KEY_RIGHT): begin
                key_valid = 1'b1;
                key_dir   = DIR_RIGHT;
            end
            (keycode == KEY_DOWN): begin
                key_valid = 1'b1;
                key_dir   = DIR_DOWN;
            end
            (keycode == KEY_LEFT): begin
                key_valid = 1'b1;
                key_dir   = DIR_LEFT;
            end
            default: begin
                key_valid = 1'b0;
                key_dir   = DIR_UP;
            end
        endcase
    end

    // Whether the neighbouring cell in key_dir is on the grid
    logic can_move;

    // Position is cell-aligned here, so checking one cell ahead
    // keeps the whole move inside the grid without any wrap.
    always_comb begin
        can_move = 1'b0;
        unique case (key_dir)
            DIR_UP:    can_move = (y_q >= CELL);
            DIR_RIGHT: can_move = (x_q <= X_MAX - CELL);
            DIR_DOWN:  can_move = (y_q <= Y_MAX - CELL);
            DIR_LEFT:  can_move = (x_q >= CELL);
            default:   can_move = 1'b0;
        endcase
    end

    // One STEP towards the active direction and the alignment test
    logic [1:0] step_dir;
    logic [9:0] step_x;
    logic [9:0] step_y;
    logic       aligned;

    // New cells use the key; moves in progress use stored facing
    always_comb begin
        step_dir = (state_q == IDLE) ? key_dir : dir_q;
        step_x   = x_q;
        step_y   = y_q;
        unique case (step_dir)
            DIR_UP:    step_y = y_q - STEP;
            DIR_RIGHT: step_x = x_q + STEP;
            DIR_DOWN:  step_y = y_q + STEP;
            DIR_LEFT:  step_x = x_q - STEP;
            default: begin
                step_x = x_q;
                step_y = y_q;
            end
        endcase
        if (step_dir == DIR_UP || step_dir == DIR_DOWN) begin
            aligned = (step_y[4:0] == 5'd0);
        end else begin
            aligned = (step_x[4:0] == 5'd0);
        end
    end

    // Next-state and next-output logic, evaluated only on ticks
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        dir_d = key_dir;
                        if (can_move) begin
                            x_d     = step_x;
                            y_d     = step_y;
                            state_d = aligned ? IDLE : MOVE;
                        end
                    end
                end
                MOVE: begin
                    x_d = step_x;
                    y_d = step_y;
                    if (aligned) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        moving_d = (state_d == MOVE);
    end

    // State and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            x_q      <= START_X;
            y_q      <= START_Y;
            dir_q    <= DIR_UP;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            moving_q <= moving_d;
        end
    end

    assign TankX   = x_q;
    assign TankY   = y_q;
    assign TankDir = dir_q;
    assign Moving  = moving_q;

endmodule
